// File: rtl/confreg_responder.sv
// rtl/confreg_responder.sv - memory-mapped config responder on the data SRAM port
// Scratch, LED, synchronized switch and a compare/interrupt timer behind a 256-byte window.
module confreg_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hBFAF_0000,
    parameter int          LED_W     = 16,
    parameter int          SW_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sram_en,
    input  logic [3:0]        sram_we,
    input  logic [31:0]       sram_addr,
    input  logic [31:0]       sram_wdata,
    output logic [31:0]       sram_rdata,
    output logic [LED_W-1:0]  led,
    input  logic [SW_W-1:0]   switch,
    output logic              timer_irq
);

    localparam logic [5:0] OFF_SCRATCH0 = 6'h00;
    localparam logic [5:0] OFF_SCRATCH1 = 6'h01;
    localparam logic [5:0] OFF_LED      = 6'h04;
    localparam logic [5:0] OFF_SWITCH   = 6'h05;
    localparam logic [5:0] OFF_TIMER    = 6'h08;
    localparam logic [5:0] OFF_CMP      = 6'h09;
    localparam logic [5:0] OFF_STATUS   = 6'h0A;
    localparam logic [5:0] OFF_CTRL     = 6'h0B;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    logic [31:0]      scratch0_q, scratch1_q;
    logic [LED_W-1:0] led_q;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
    logic [31:0]      timer_q, cmp_q;
    logic             match_q, irq_en_q, timer_en_q, irq_q;
    logic [31:0]      rdata_q;

    logic             hit, rd_req, wr_req;
    logic [5:0]       off;
    logic [31:0]      byte_mask;
    logic             wr_scratch0, wr_scratch1, wr_led, wr_timer, wr_cmp, wr_status, wr_ctrl;
    logic             unused_addr_bits;

    logic [LED_W-1:0] led_next;
    logic [31:0]      timer_next;
    logic             match_next, irq_en_next, timer_en_next, cmp_hit;
    logic [31:0]      led_ext, sw_ext, rd_word;

    assign hit       = sram_en && (sram_addr[31:8] == BASE_ADDR[31:8]);
    assign off       = sram_addr[7:2];
    assign wr_req    = hit && (sram_we != 4'b0000);
    assign rd_req    = sram_en && (sram_we == 4'b0000);
    assign byte_mask = {{8{sram_we[3]}}, {8{sram_we[2]}}, {8{sram_we[1]}}, {8{sram_we[0]}}};
    assign unused_addr_bits = ^sram_addr[1:0];

    assign wr_scratch0 = wr_req && (off == OFF_SCRATCH0);
    assign wr_scratch1 = wr_req && (off == OFF_SCRATCH1);
    assign wr_led      = wr_req && (off == OFF_LED);
    assign wr_timer    = wr_req && (off == OFF_TIMER);
    assign wr_cmp      = wr_req && (off == OFF_CMP);
    assign wr_status   = wr_req && (off == OFF_STATUS);
    assign wr_ctrl     = wr_req && (off == OFF_CTRL);

    // Compare on the pre-update timer; a set beats a same-cycle W1C.
    always_comb begin
        cmp_hit    = timer_en_q && (timer_q == cmp_q);
        match_next = cmp_hit ||
                     (match_q && !(wr_status && sram_we[0] && sram_wdata[0]));

        irq_en_next   = irq_en_q;
        timer_en_next = timer_en_q;
        if (wr_ctrl && sram_we[0]) begin
            irq_en_next   = sram_wdata[0];
            timer_en_next = sram_wdata[1];
        end

        if (wr_timer) begin
            timer_next = merge(timer_q, sram_wdata, byte_mask);
        end else if (timer_en_q) begin
            timer_next = timer_q + 32'd1;
        end else begin
            timer_next = timer_q;
        end

        led_next = led_q;
        if (wr_led) begin
            for (int i = 0; i < LED_W; i++) begin
                led_next[i] = byte_mask[i] ? sram_wdata[i] : led_q[i];
            end
        end
    end

    always_comb begin
        led_ext = '0;
        led_ext[LED_W-1:0] = led_q;
        sw_ext = '0;
        sw_ext[SW_W-1:0] = sw_sync_q;

        rd_word = 32'h0;
        if (hit) begin
            case (off)
                OFF_SCRATCH0: rd_word = scratch0_q;
                OFF_SCRATCH1: rd_word = scratch1_q;
                OFF_LED:      rd_word = led_ext;
                OFF_SWITCH:   rd_word = sw_ext;
                OFF_TIMER:    rd_word = timer_q;
                OFF_CMP:      rd_word = cmp_q;
                OFF_STATUS:   rd_word = {31'h0, match_q};
                OFF_CTRL:     rd_word = {30'h0, timer_en_q, irq_en_q};
                default:      rd_word = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch0_q <= 32'h0;
            scratch1_q <= 32'h0;
            led_q      <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            timer_q    <= 32'h0;
            cmp_q      <= 32'hFFFF_FFFF;
            match_q    <= 1'b0;
            irq_en_q   <= 1'b0;
            timer_en_q <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            if (wr_scratch0) scratch0_q <= merge(scratch0_q, sram_wdata, byte_mask);
            if (wr_scratch1) scratch1_q <= merge(scratch1_q, sram_wdata, byte_mask);
            if (wr_cmp)      cmp_q      <= merge(cmp_q, sram_wdata, byte_mask);
            led_q      <= led_next;
            sw_meta_q  <= switch;
            sw_sync_q  <= sw_meta_q;
            timer_q    <= timer_next;
            match_q    <= match_next;
            irq_en_q   <= irq_en_next;
            timer_en_q <= timer_en_next;
            irq_q      <= match_next & irq_en_next;
            if (rd_req) rdata_q <= rd_word;
        end
    end

    assign sram_rdata = rdata_q;
    assign led        = led_q;
    assign timer_irq  = irq_q;

endmodule

// File: tb/tb_confreg_responder.sv
// tb/tb_confreg_responder.sv - directed and randomized bench for confreg_responder
// Word-array reference model stepped once per clock; every cycle checks rdata, led and irq.
module tb_confreg_responder;

    localparam logic [31:0] BASE = 32'hBFAF_0000;
    localparam logic [31:0] A_S0 = BASE + 32'h00;
    localparam logic [31:0] A_S1 = BASE + 32'h04;
    localparam logic [31:0] A_LED = BASE + 32'h10;
    localparam logic [31:0] A_SW = BASE + 32'h14;
    localparam logic [31:0] A_TMR = BASE + 32'h20;
    localparam logic [31:0] A_CMP = BASE + 32'h24;
    localparam logic [31:0] A_STS = BASE + 32'h28;
    localparam logic [31:0] A_CTL = BASE + 32'h2C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sram_en = 1'b0;
    logic [3:0]  sram_we = 4'h0;
    logic [31:0] sram_addr = 32'h0;
    logic [31:0] sram_wdata = 32'h0;
    logic [31:0] sram_rdata;
    logic [15:0] led;
    logic [7:0]  sw = 8'h0;
    logic        timer_irq;

    confreg_responder #(.BASE_ADDR(BASE), .LED_W(16), .SW_W(8)) dut (
        .clk(clk), .reset(reset), .sram_en(sram_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .led(led), .switch(sw), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: one word per offset; index 5 is the switch, 10 status, 11 ctrl.
    logic [31:0] m [0:63];
    logic [31:0] m_rd;
    logic        m_irq;
    logic [7:0]  m_s1, m_s2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wmask(input int off);
        case (off)
            0, 1, 8, 9: return 32'hFFFF_FFFF;
            4:          return 32'h0000_FFFF;
            11:         return 32'h0000_0003;
            default:    return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m[i] = 32'h0;
        m[9] = 32'hFFFF_FFFF;
        m_rd = 32'h0;
        m_irq = 1'b0;
        m_s1 = 8'h0;
        m_s2 = 8'h0;
    endtask

    task automatic step(input logic en, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wd);
        logic hit, ten, set, wr;
        int off;
        logic [31:0] bm;
        sram_en = en; sram_we = we; sram_addr = addr; sram_wdata = wd;
        hit = en && (addr[31:8] == BASE[31:8]);
        wr  = hit && (we != 4'h0);
        off = int'(addr[7:2]);
        bm  = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
        ten = m[11][1];
        set = ten && (m[8] == m[9]);
        if (en && we == 4'h0)
            m_rd = !hit ? 32'h0 : (off == 5) ? {24'h0, m_s2} : m[off];
        if (ten && !(wr && off == 8)) m[8] = m[8] + 32'd1;
        if (wr) begin
            if (off == 10) begin
                if (bm[0] && wd[0]) m[10] = 32'h0;
            end else begin
                m[off] = ((m[off] & ~bm) | (wd & bm)) & wmask(off);
            end
        end
        if (set) m[10] = 32'h1;
        m_irq = m[10][0] & m[11][0];
        m_s2 = m_s1;
        m_s1 = sw;
        @(posedge clk);
        #1;
        chk("rdata", sram_rdata, m_rd);
        chk("led", {16'h0, led}, m[4]);
        chk("irq", {31'h0, timer_irq}, {31'h0, m_irq});
        sram_en = 1'b0; sram_we = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 4'h0, a, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        step(1'b1, we, a, d);
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] addr;
        logic [3:0]  we;
        int k;
        model_reset();
        #1;
        chk("rst_rdata", sram_rdata, 32'h0);
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_irq", {31'h0, timer_irq}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        rd(A_S0);  chk("rd_s0", sram_rdata, 32'h0);
        rd(A_LED); chk("rd_led", sram_rdata, 32'h0);
        rd(A_CMP); chk("rd_cmp", sram_rdata, 32'hFFFF_FFFF);
        rd(A_CTL); chk("rd_ctl", sram_rdata, 32'h0);

        wr(A_S0, 32'h1122_3344, 4'hF);
        wr(A_S0, 32'hAABB_CCDD, 4'b0101);
        chk("wr_keeps_rdata", sram_rdata, 32'h0);
        rd(A_S0);  chk("byte_merge", sram_rdata, 32'h11BB_33DD);

        wr(A_LED, 32'hFFFF_1234, 4'hF);
        chk("led_out", {16'h0, led}, 32'h0000_1234);
        rd(A_LED); chk("led_rd", sram_rdata, 32'h0000_1234);

        wr(A_CMP, 32'd10, 4'hF);
        wr(A_TMR, 32'd0, 4'hF);
        wr(A_CTL, 32'd3, 4'hF);
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("irq_before_match", {31'h0, timer_irq}, 32'h0);
        end
        idle();
        chk("irq_at_match", {31'h0, timer_irq}, 32'h1);
        rd(A_STS); chk("status_set", sram_rdata, 32'h1);
        wr(A_STS, 32'h1, 4'hF);
        chk("irq_cleared", {31'h0, timer_irq}, 32'h0);
        wr(A_TMR, 32'd9, 4'hF);
        idle();
        wr(A_STS, 32'h1, 4'hF);
        chk("set_beats_clear", {31'h0, timer_irq}, 32'h1);
        rd(A_STS); chk("status_kept", sram_rdata, 32'h1);

        wr(A_TMR, 32'hFFFF_FFFE, 4'hF);
        rd(A_TMR); chk("wrap0", sram_rdata, 32'hFFFF_FFFE);
        rd(A_TMR); chk("wrap1", sram_rdata, 32'hFFFF_FFFF);
        rd(A_TMR); chk("wrap2", sram_rdata, 32'h0000_0000);
        wr(A_TMR, 32'h0000_0100, 4'hF);
        rd(A_TMR); chk("timer_load", sram_rdata, 32'h0000_0100);

        rd(A_S0);
        rd(BASE + 32'h100); chk("miss_rd", sram_rdata, 32'h0);
        rd(A_S0);
        rd(BASE + 32'h3C);  chk("unmapped_rd", sram_rdata, 32'h0);
        wr(BASE + 32'h100, 32'hFFFF_FFFF, 4'hF);
        wr(BASE + 32'h3C, 32'hFFFF_FFFF, 4'hF);
        rd(A_S0);  chk("miss_no_write", sram_rdata, 32'h11BB_33DD);
        rd(A_S1);  chk("miss_no_write_s1", sram_rdata, 32'h0);

        sw = 8'hA5;
        idle();
        idle();
        rd(A_SW);  chk("switch_sync", sram_rdata, 32'h0000_00A5);

        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            case (k)
                0: addr = A_S0;  1: addr = A_S1;  2: addr = A_LED; 3: addr = A_SW;
                4: addr = A_TMR; 5: addr = A_CMP; 6: addr = A_STS; 7: addr = A_CTL;
                8: addr = BASE + {24'h0, 8'($urandom)};
                default: addr = ($urandom_range(0, 1) == 1) ? BASE + 32'h100 : 32'($urandom);
            endcase
            if (k < 8) addr[1:0] = 2'($urandom);
            we = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 15) == 0) sw = 8'($urandom);
            step($urandom_range(0, 9) != 0, we, addr, 32'($urandom));
        end

        wr(A_S0, 32'hCAFE_F00D, 4'hF);
        wr(A_LED, 32'h0000_BEEF, 4'hF);
        rd(A_S0);  chk("pre_reset_rd", sram_rdata, 32'hCAFE_F00D);
        sram_en = 1'b1; sram_we = 4'h0; sram_addr = A_S0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_rdata", sram_rdata, 32'h0);
        chk("async_rst_led", {16'h0, led}, 32'h0);
        chk("async_rst_irq", {31'h0, timer_irq}, 32'h0);
        sram_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd(A_S0);  chk("post_rst_s0", sram_rdata, 32'h0);
        rd(A_CMP); chk("post_rst_cmp", sram_rdata, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
